idu_stage: RTL and testbench
============================

Name: idu_stage

Overview:
- Registered decode stage between the ifu and the exu.
- Accepts one instruction per cycle on a valid/ready handshake and reads rs1/rs2 from the regfile.
- Generates the sign-extended immediate and detects read-after-write hazards against in-flight writers using a per-register pending-write scoreboard.
- Holds the decoded bundle in a one-entry output register, supports flush on redirect, and counts hazard stall cycles.

Parameters:
- XLEN, 32, datapath width of pc, operands and immediate.
- PEND_W, 2, width of each per-register pending-write counter; max in-flight writers per rd = 2^PEND_W-1.
- CNT_W, 32, width of the stall performance counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_pc  in  XLEN  pc from ifu
- i_inst  in  32  instruction from ifu
- i_valid  in  1  ifu beat valid
- o_ready  out  1  stage can accept this cycle
- o_reg1_raddr  out  5  i_inst[19:15], combinational
- o_reg2_raddr  out  5  i_inst[24:20], combinational
- i_reg1_rdata  in  XLEN  regfile read data 1, same cycle
- i_reg2_rdata  in  XLEN  regfile read data 2, same cycle
- o_valid  out  1  output register holds a bundle
- i_ready  in  1  exu accepts bundle
- o_pc, o_imm, o_src1, o_src2  out  XLEN  registered bundle
- o_inst  out  32  registered instruction
- o_rd  out  5  registered destination
- o_rd_wen  out  1  registered destination write intent
- i_wb_valid  in  1  writeback retiring a register write
- i_wb_rd  in  5  retiring destination
- i_flush  in  1  redirect; kill buffered bundle
- o_sb_err  out  1  one-cycle pulse: writeback to a register with pending==0
- o_stall_cnt  out  CNT_W  hazard stall cycle count

Behaviour:
- Reset (i_rst=1 at posedge): o_valid=0, all pending counters=0, o_stall_cnt=0, o_sb_err=0, bundle registers=0. Reset wins over all other inputs.
- Source use:
  - uses_rs1 = opcode not in {0110111, 0010111, 1101111}.
  - uses_rs2 = opcode in {0110011, 0100011, 1100011}.
  - Register x0 is never a hazard.
- rd_wen = (opcode not in {0100011, 1100011}) && rd!=0.
- Immediate:
  - I: opcodes 0000011, 0010011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode gives 0. Sign-extended to XLEN.
- hazard (combinational, registered counters only, no same-cycle wb bypass):
  - (uses_rs1 && pend[rs1]!=0)
  - || (uses_rs2 && pend[rs2]!=0)
  - || (rd_wen && pend[rd]==max).
- o_ready = (!o_valid || i_ready) && !hazard && !i_flush.
- Accept = i_valid && o_ready:
  - Bundle registers load pc/inst/imm/rdata/rd/rd_wen.
  - o_valid=1 next cycle.
  - If rd_wen, pend[rd] += 1.
- Drain: o_valid && i_ready && !accept → o_valid=0 next cycle. Drain plus accept in the same cycle gives back-to-back throughput of 1/cycle.
- Outputs stay stable while o_valid && !i_ready.
- Flush:
  - o_valid=0 next cycle and no accept that cycle.
  - Any handoff in the flush cycle is cancelled; exu flushes too.
  - If o_valid && o_rd_wen, pend[o_rd] -= 1.
- Writeback: i_wb_valid && i_wb_rd!=0 → pend[i_wb_rd] -= 1. If pend==0, the counter is unchanged and o_sb_err pulses next cycle.
- Simultaneous updates to one counter (issue +1, flush -1, wb -1) sum in one cycle. The result clamps at 0 and at max; the sb_err rule still applies.
- o_stall_cnt increments each cycle with i_valid && hazard && !i_flush; wraps at 2^CNT_W.

Test Plan:
- Reset mid-stream with o_valid=1 and pend[5]=2 → next cycle o_valid=0, pend all 0, an instruction reading x5 accepted immediately.
- addi x5,x0,7 then add x6,x5,x5 → second held (o_ready=0) and o_stall_cnt +1 per cycle until i_wb_valid/rd=5. Accept occurs the cycle after wb, src1=src2=regfile x5.
- Back-to-back independent addi stream with i_ready=1 → one o_valid bundle per cycle. imm for addi x1,x0,-1 is 0xFFFFFFFF. sw imm offset -4 → 0xFFFFFFFC, o_rd_wen=0.
- i_ready=0 for 3 cycles with o_valid=1 → o_pc/o_inst/o_src1 unchanged, o_ready=0.
- Buffered lui x7 (pend[7]=1), i_flush=1 → o_valid=0, pend[7]=0. A later add reading x7 does not stall.
- i_wb_valid with i_wb_rd=9, pend[9]=0 → o_sb_err=1 for exactly one cycle, pend[9] stays 0. Writing three times to x3 with no wb (PEND_W=2) → third accepted, fourth stalls.

Source files
------------

// File: rtl/idu_stage.sv
// rtl/idu_stage.sv - decode stage with pending-write scoreboard, one-entry output register and stall counter
module idu_stage #(
    parameter int XLEN   = 32,
    parameter int PEND_W = 2,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [31:0]       i_inst,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [4:0]        o_reg1_raddr,
    output logic [4:0]        o_reg2_raddr,
    input  logic [XLEN-1:0]   i_reg1_rdata,
    input  logic [XLEN-1:0]   i_reg2_rdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_imm,
    output logic [XLEN-1:0]   o_src1,
    output logic [XLEN-1:0]   o_src2,
    output logic [31:0]       o_inst,
    output logic [4:0]        o_rd,
    output logic              o_rd_wen,
    input  logic              i_wb_valid,
    input  logic [4:0]        i_wb_rd,
    input  logic              i_flush,
    output logic              o_sb_err,
    output logic [CNT_W-1:0]  o_stall_cnt
);
    localparam logic [PEND_W-1:0] PMAX = '1;

    logic [6:0]        w_opcode;
    logic [4:0]        w_rs1, w_rs2, w_rd;
    logic              w_uses_rs1, w_uses_rs2, w_rd_wen;
    logic              w_hazard, w_accept;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic [PEND_W-1:0] w_pend_nxt [32];

    logic              r_valid;
    logic [XLEN-1:0]   r_pc, r_imm, r_src1, r_src2;
    logic [31:0]       r_inst;
    logic [4:0]        r_rd;
    logic              r_rd_wen;
    logic              r_sb_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [PEND_W-1:0] r_pend [32];

    assign w_opcode = i_inst[6:0];
    assign w_rd     = i_inst[11:7];
    assign w_rs1    = i_inst[19:15];
    assign w_rs2    = i_inst[24:20];

    assign w_uses_rs1 = !(w_opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
    assign w_uses_rs2 = w_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    assign w_rd_wen   = !(w_opcode inside {7'b0100011, 7'b1100011}) && (w_rd != 5'd0);

    always_comb begin
        w_imm32 = 32'd0;
        case (w_opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            7'b0100011:
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            7'b1100011:
                w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                w_imm32 = {i_inst[31:12], 12'd0};
            7'b1101111:
                w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            default:
                w_imm32 = 32'd0;
        endcase
    end
    assign w_imm = XLEN'($signed(w_imm32));

    // Only registered counters are consulted; a writeback this cycle frees the source next cycle.
    assign w_hazard = (w_uses_rs1 && (w_rs1 != 5'd0) && (r_pend[w_rs1] != '0))
                   || (w_uses_rs2 && (w_rs2 != 5'd0) && (r_pend[w_rs2] != '0))
                   || (w_rd_wen && (r_pend[w_rd] == PMAX));

    assign o_ready  = (!r_valid || i_ready) && !w_hazard && !i_flush;
    assign w_accept = i_valid && o_ready;

    // Issue, flush and writeback contributions are summed in a widened signed space, then clamped.
    always_comb begin
        logic [PEND_W+1:0] w_sum;
        logic              w_inc, w_dec_f, w_dec_w;
        w_sum   = '0;
        w_inc   = 1'b0;
        w_dec_f = 1'b0;
        w_dec_w = 1'b0;
        for (int i = 0; i < 32; i++) begin
            w_inc   = w_accept && w_rd_wen && (w_rd == 5'(i));
            w_dec_f = i_flush && r_valid && r_rd_wen && (r_rd == 5'(i));
            w_dec_w = i_wb_valid && (i_wb_rd != 5'd0) && (i_wb_rd == 5'(i)) && (r_pend[i] != '0);
            w_sum   = {2'b00, r_pend[i]} + (PEND_W+2)'(w_inc)
                    - (PEND_W+2)'(w_dec_f) - (PEND_W+2)'(w_dec_w);
            if (w_sum[PEND_W+1])
                w_pend_nxt[i] = '0;
            else if (w_sum[PEND_W])
                w_pend_nxt[i] = PMAX;
            else
                w_pend_nxt[i] = w_sum[PEND_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_inst      <= '0;
            r_rd        <= '0;
            r_rd_wen    <= 1'b0;
            r_sb_err    <= 1'b0;
            r_stall_cnt <= '0;
            for (int i = 0; i < 32; i++) r_pend[i] <= '0;
        end else begin
            if (i_flush)
                r_valid <= 1'b0;
            else if (w_accept)
                r_valid <= 1'b1;
            else if (i_ready)
                r_valid <= 1'b0;
            if (w_accept) begin
                r_pc     <= i_pc;
                r_inst   <= i_inst;
                r_imm    <= w_imm;
                r_src1   <= i_reg1_rdata;
                r_src2   <= i_reg2_rdata;
                r_rd     <= w_rd;
                r_rd_wen <= w_rd_wen;
            end
            r_sb_err <= i_wb_valid && (i_wb_rd != 5'd0) && (r_pend[i_wb_rd] == '0);
            if (i_valid && w_hazard && !i_flush)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            for (int i = 0; i < 32; i++) r_pend[i] <= w_pend_nxt[i];
        end
    end

    assign o_reg1_raddr = w_rs1;
    assign o_reg2_raddr = w_rs2;
    assign o_valid      = r_valid;
    assign o_pc         = r_pc;
    assign o_imm        = r_imm;
    assign o_src1       = r_src1;
    assign o_src2       = r_src2;
    assign o_inst       = r_inst;
    assign o_rd         = r_rd;
    assign o_rd_wen     = r_rd_wen;
    assign o_sb_err     = r_sb_err;
    assign o_stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_idu_stage.sv
// tb/tb_idu_stage.sv - table-driven and sequence checks for idu_stage
module tb_idu_stage;
    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_ready, i_wb_valid, i_flush;
    logic [31:0] i_pc, i_inst, i_reg1_rdata, i_reg2_rdata;
    logic [4:0]  i_wb_rd;
    logic        o_ready, o_valid, o_rd_wen, o_sb_err;
    logic [4:0]  o_reg1_raddr, o_reg2_raddr, o_rd;
    logic [31:0] o_pc, o_imm, o_src1, o_src2, o_inst, o_stall_cnt;

    always #5 i_clk = ~i_clk;

    idu_stage #(.XLEN(32), .PEND_W(2), .CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_inst(i_inst), .i_valid(i_valid),
        .o_ready(o_ready), .o_reg1_raddr(o_reg1_raddr), .o_reg2_raddr(o_reg2_raddr),
        .i_reg1_rdata(i_reg1_rdata), .i_reg2_rdata(i_reg2_rdata), .o_valid(o_valid),
        .i_ready(i_ready), .o_pc(o_pc), .o_imm(o_imm), .o_src1(o_src1), .o_src2(o_src2),
        .o_inst(o_inst), .o_rd(o_rd), .o_rd_wen(o_rd_wen), .i_wb_valid(i_wb_valid),
        .i_wb_rd(i_wb_rd), .i_flush(i_flush), .o_sb_err(o_sb_err), .o_stall_cnt(o_stall_cnt)
    );

    function automatic logic [31:0] rf(input logic [4:0] a);
        return 32'hA000_0000 | (32'(a) << 8) | 32'(a);
    endfunction

    assign i_reg1_rdata = rf(o_reg1_raddr);
    assign i_reg2_rdata = rf(o_reg2_raddr);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        i_valid = v;
        i_inst  = inst;
        i_pc    = pc;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{32'hFFF00093, 32'hFFFFFFFF, 5'd1,  1'b1};
        tbl[1] = '{32'hFE252E23, 32'hFFFFFFFC, 5'd28, 1'b0};
        tbl[2] = '{32'h123453B7, 32'h12345000, 5'd7,  1'b1};
        tbl[3] = '{32'hFFFFF597, 32'hFFFFF000, 5'd11, 1'b1};
        tbl[4] = '{32'h0010066F, 32'h00000800, 5'd12, 1'b1};
        tbl[5] = '{32'hFEE68CE3, 32'hFFFFFFF8, 5'd25, 1'b0};
        tbl[6] = '{32'h7FF02783, 32'h000007FF, 5'd15, 1'b1};
        tbl[7] = '{32'hFFFFF80F, 32'h00000000, 5'd16, 1'b1};
        tbl[8] = '{32'h015A0033, 32'h00000000, 5'd0,  1'b0};

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_wb_valid = 1'b0; i_flush = 1'b0;
        i_pc = '0; i_inst = '0; i_wb_rd = '0;
        tick();
        tick();
        i_rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_stall", o_stall_cnt, 32'd0);
        chk("rst_sberr", 32'(o_sb_err), 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_imm", o_imm, 32'd0);

        // back-to-back stream, one bundle per cycle
        i_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, tbl[k].inst, 32'h1000 + 32'(4 * k));
            #1;
            chk("tbl_ready", 32'(o_ready), 32'd1);
            tick();
            chk("tbl_valid", 32'(o_valid), 32'd1);
            chk("tbl_pc", o_pc, 32'h1000 + 32'(4 * k));
            chk("tbl_inst", o_inst, tbl[k].inst);
            chk("tbl_imm", o_imm, tbl[k].imm);
            chk("tbl_rd", 32'(o_rd), 32'(tbl[k].rd));
            chk("tbl_wen", 32'(o_rd_wen), 32'(tbl[k].wen));
            chk("tbl_src1", o_src1, rf(tbl[k].inst[19:15]));
            chk("tbl_src2", o_src2, rf(tbl[k].inst[24:20]));
        end
        i_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(o_valid), 32'd0);

        // RAW hazard on x5 released by writeback
        do_reset();
        drive(1'b1, 32'h00700293, 32'h2000);
        #1;
        chk("raw_first_ready", 32'(o_ready), 32'd1);
        tick();
        drive(1'b1, 32'h00528333, 32'h2004);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("raw_stall_ready", 32'(o_ready), 32'd0);
            tick();
        end
        chk("raw_stall_cnt3", o_stall_cnt, 32'd3);
        chk("raw_drained", 32'(o_valid), 32'd0);
        i_wb_valid = 1'b1;
        i_wb_rd    = 5'd5;
        #1;
        chk("raw_wb_ready", 32'(o_ready), 32'd0);
        tick();
        i_wb_valid = 1'b0;
        chk("raw_stall_cnt4", o_stall_cnt, 32'd4);
        chk("raw_sberr", 32'(o_sb_err), 32'd0);
        #1;
        chk("raw_post_wb_ready", 32'(o_ready), 32'd1);
        tick();
        chk("raw_valid", 32'(o_valid), 32'd1);
        chk("raw_rd", 32'(o_rd), 32'd6);
        chk("raw_src1", o_src1, rf(5'd5));
        chk("raw_src2", o_src2, rf(5'd5));
        chk("raw_stall_final", o_stall_cnt, 32'd4);

        // exu backpressure holds the bundle
        i_ready = 1'b0;
        drive(1'b1, 32'h00300493, 32'h3000);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ready", 32'(o_ready), 32'd0);
            tick();
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_pc", o_pc, 32'h2004);
            chk("hold_inst", o_inst, 32'h00528333);
            chk("hold_src1", o_src1, rf(5'd5));
        end
        chk("hold_stall", o_stall_cnt, 32'd4);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();

        // flush of a buffered writer releases its pending count
        do_reset();
        i_ready = 1'b0;
        drive(1'b1, 32'h123453B7, 32'h4000);
        tick();
        chk("fl_buffered", 32'(o_valid), 32'd1);
        drive(1'b1, 32'h00738433, 32'h4004);
        i_flush = 1'b1;
        #1;
        chk("fl_ready", 32'(o_ready), 32'd0);
        tick();
        i_flush = 1'b0;
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_stall", o_stall_cnt, 32'd0);
        #1;
        chk("fl_after_ready", 32'(o_ready), 32'd1);
        tick();
        chk("fl_add_valid", 32'(o_valid), 32'd1);
        chk("fl_add_rd", 32'(o_rd), 32'd8);
        chk("fl_add_pc", o_pc, 32'h4004);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();

        // writeback to an idle register
        do_reset();
        i_wb_valid = 1'b1;
        i_wb_rd    = 5'd9;
        tick();
        i_wb_valid = 1'b0;
        chk("sberr_pulse", 32'(o_sb_err), 32'd1);
        tick();
        chk("sberr_clear", 32'(o_sb_err), 32'd0);
        drive(1'b1, 32'h00048533, 32'h5000);
        #1;
        chk("sberr_x9_ready", 32'(o_ready), 32'd1);
        tick();
        chk("sberr_x9_valid", 32'(o_valid), 32'd1);
        i_valid = 1'b0;
        tick();

        // pending counter saturation on x3
        do_reset();
        i_ready = 1'b1;
        drive(1'b1, 32'h00100193, 32'h6000);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("sat_ready", 32'(o_ready), 32'd1);
            tick();
        end
        #1;
        chk("sat_full_ready", 32'(o_ready), 32'd0);
        tick();
        chk("sat_stall1", o_stall_cnt, 32'd1);
        i_wb_valid = 1'b1;
        i_wb_rd    = 5'd3;
        #1;
        chk("sat_wb_ready", 32'(o_ready), 32'd0);
        tick();
        i_wb_valid = 1'b0;
        #1;
        chk("sat_freed_ready", 32'(o_ready), 32'd1);
        tick();
        chk("sat_valid", 32'(o_valid), 32'd1);
        chk("sat_stall2", o_stall_cnt, 32'd2);
        i_valid = 1'b0;
        tick();

        // reset mid-stream with pend[5]=2 and a live bundle
        do_reset();
        i_ready = 1'b1;
        drive(1'b1, 32'h00700293, 32'h7000);
        tick();
        tick();
        i_ready = 1'b0;
        drive(1'b1, 32'h00528333, 32'h7008);
        tick();
        chk("mid_stall", o_stall_cnt, 32'd1);
        chk("mid_valid", 32'(o_valid), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_stall", o_stall_cnt, 32'd0);
        chk("mid_rst_inst", o_inst, 32'd0);
        #1;
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        tick();
        chk("mid_add_valid", 32'(o_valid), 32'd1);
        chk("mid_add_rd", 32'(o_rd), 32'd6);
        i_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
